// File: rtl/keyboard_pkg.sv
// Shared types and constants for the keyboard event path.
package keyboard_pkg;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Controller replies / error bytes that never start a key event
  localparam int N_DROP = 6;
  localparam logic [N_DROP-1:0][7:0] SC_DROP = {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};

  localparam logic [31:0] OFS_STATUS = 32'd0;
  localparam logic [31:0] OFS_DATA   = 32'd4;

  typedef struct packed {
    logic       ext;
    logic       rel;
    logic [7:0] code;
  } key_event_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } kbd_state_t;

  function automatic logic is_dropped(input logic [7:0] c);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < N_DROP; i++)
      if (c == SC_DROP[i]) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous FIFO of key events; head is shown combinationally.
module key_event_fifo
  import keyboard_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  key_event_t    din,
  output key_event_t    head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  key_event_t        mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  // A pop frees a slot in the same edge, so a full FIFO still accepts a push
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage: no reset needed, reads are qualified by empty
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/kbd_event_queue.sv
// Folds E0/F0 scan-code prefixes into key events, queues them and
// exposes a STATUS/DATA register pair to the CPU.
module kbd_event_queue
  import keyboard_pkg::*;
#(
  parameter int DEPTH          = 8,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  code,
  input  logic        code_valid,
  input  logic        en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        irq
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  kbd_state_t    state;
  logic [TW-1:0] tmo_cnt;
  logic          overflow;

  key_event_t    ev, head;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, rd_req, pop_eff, ovf_clr;
  logic          sel_data;
  logic          unused_ok;

  assign unused_ok = ^{addr[31:3], addr[1:0], wdata[30:0]};

  assign sel_data = (addr[2] == OFS_DATA[2]);
  assign rd_req   = en & ~we & sel_data;
  assign pop_eff  = rd_req & ~empty;
  assign ovf_clr  = en & we & ~sel_data & wdata[31];

  // Final byte of a sequence: not a prefix and not a dropped reply in IDLE
  assign push = code_valid && (code != SC_EXT) && (code != SC_BRK) &&
                !(state == IDLE && is_dropped(code));

  assign ev.ext  = (state == EXT) || (state == EXT_BRK);
  assign ev.rel  = (state == BRK) || (state == EXT_BRK);
  assign ev.code = code;

  // Prefix decoder with idle timeout; a new byte takes priority over timeout
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      tmo_cnt <= '0;
    end else if (code_valid) begin
      tmo_cnt <= '0;
      if (code == SC_EXT) begin
        state <= EXT;
      end else if (code == SC_BRK) begin
        case (state)
          IDLE:    state <= BRK;
          EXT:     state <= EXT_BRK;
          default: state <= state;
        endcase
      end else begin
        state <= IDLE;
      end
    end else if (state != IDLE) begin
      if (tmo_cnt == T_LAST) begin
        state   <= IDLE;
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end else begin
      tmo_cnt <= '0;
    end
  end

  // Sticky overflow: a dropped push sets it, and set beats a same-edge clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          overflow <= 1'b0;
    else if (push && full && !pop_eff)   overflow <= 1'b1;
    else if (ovf_clr)                    overflow <= 1'b0;
  end

  key_event_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (rd_req),
    .din   (ev),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign irq = ~empty;

  // Register read mux
  always_comb begin
    rdata = '0;
    if (en) begin
      if (sel_data) begin
        rdata[31] = ~empty;
        if (!empty) rdata[9:0] = head;
      end else begin
        rdata[31]    = overflow;
        rdata[22:16] = 7'(count);
        rdata[0]     = empty;
      end
    end
  end

endmodule

// File: tb/tb_kbd_event_queue.sv
// Directed bench for kbd_event_queue with small DEPTH and timeout.
module tb_kbd_event_queue;

  logic        clk;
  logic        reset;
  logic [7:0]  code;
  logic        code_valid;
  logic        en;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  kbd_event_queue #(.DEPTH(8), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .code       (code),
    .code_valid (code_valid),
    .en         (en),
    .addr       (addr),
    .wdata      (wdata),
    .we         (we),
    .rdata      (rdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Called just after a rising edge; returns just after the next one
  task automatic send(input logic [7:0] b);
    code = b; code_valid = 1'b1;
    @(posedge clk); #1;
    code_valid = 1'b0; code = 8'h00;
  endtask

  task automatic rd(input logic a2, input logic [31:0] exp, input string tag);
    en = 1'b1; we = 1'b0; addr = a2 ? 32'd4 : 32'd0;
    @(negedge clk);
    chk(rdata, exp, tag);
    @(posedge clk); #1;
    en = 1'b0; addr = '0;
  endtask

  task automatic wr_status(input logic [31:0] d);
    en = 1'b1; we = 1'b1; addr = 32'd0; wdata = d;
    @(posedge clk); #1;
    en = 1'b0; we = 1'b0; wdata = '0;
  endtask

  initial begin
    reset = 1'b0; code = '0; code_valid = 1'b0;
    en = 1'b0; addr = '0; wdata = '0; we = 1'b0;

    // Reset state
    #12;
    en = 1'b1; addr = 32'd0; #1;
    chk(rdata, 32'h0000_0001, "rst_status");
    addr = 32'd4; #1;
    chk(rdata, 32'h0000_0000, "rst_data");
    chk({31'b0, irq}, 32'd0, "rst_irq");
    en = 1'b0; #1;
    chk(rdata, 32'h0000_0000, "en0_rdata");
    addr = '0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    // Make, break, extended make, extended break
    send(8'h1C);
    chk({31'b0, irq}, 32'd1, "irq_after_push");
    send(8'hF0); send(8'h1C);
    send(8'hE0); send(8'h75);
    send(8'hE0); send(8'hF0); send(8'h75);
    rd(1'b0, 32'h0004_0000, "status_4");
    rd(1'b1, 32'h8000_001C, "make_1c");
    rd(1'b1, 32'h8000_011C, "break_1c");
    rd(1'b1, 32'h8000_0275, "ext_make_75");
    rd(1'b1, 32'h8000_0375, "ext_break_75");
    rd(1'b0, 32'h0000_0001, "status_empty");
    rd(1'b1, 32'h0000_0000, "pop_empty");
    chk({31'b0, irq}, 32'd0, "irq_empty");

    // F0 repeated holds BRK
    send(8'hF0); send(8'hF0); send(8'h2A);
    rd(1'b1, 32'h8000_012A, "brk_hold");

    // Prefix timeout: 16 idle cycles abandons E0
    send(8'hE0);
    repeat (16) @(posedge clk);
    #1;
    send(8'h1C);
    rd(1'b1, 32'h8000_001C, "timeout_ext0");
    // 14 idle cycles keeps the prefix alive
    send(8'hE0);
    repeat (14) @(posedge clk);
    #1;
    send(8'h75);
    rd(1'b1, 32'h8000_0275, "no_timeout_ext1");

    // Controller replies dropped in IDLE
    send(8'hFA); send(8'hAA);
    rd(1'b0, 32'h0000_0001, "drop_fa_aa");

    // Overflow: 9 pushes into 8 entries
    for (int i = 1; i <= 9; i++) send(8'(i));
    rd(1'b0, 32'h8008_0000, "status_ovf");
    for (int i = 1; i <= 8; i++) rd(1'b1, 32'h8000_0000 | i, "ovf_read");
    rd(1'b0, 32'h8000_0001, "ovf_sticky");
    wr_status(32'h8000_0000);
    rd(1'b0, 32'h0000_0001, "ovf_cleared");

    // Full FIFO: push and pop on the same edge
    for (int i = 8'h11; i <= 8'h18; i++) send(8'(i));
    rd(1'b0, 32'h0008_0000, "status_full");
    code = 8'h19; code_valid = 1'b1; en = 1'b1; we = 1'b0; addr = 32'd4;
    @(negedge clk);
    chk(rdata, 32'h8000_0011, "full_pushpop_head");
    @(posedge clk); #1;
    code_valid = 1'b0; en = 1'b0; addr = '0;
    rd(1'b0, 32'h0008_0000, "full_pushpop_status");
    for (int i = 8'h12; i <= 8'h19; i++) rd(1'b1, 32'h8000_0000 | i, "full_tail_read");
    rd(1'b0, 32'h0000_0001, "full_drained");

    // Overflow set and clear on the same edge: set wins
    for (int i = 1; i <= 8; i++) send(8'(i));
    code = 8'h33; code_valid = 1'b1; en = 1'b1; we = 1'b1; addr = 32'd0; wdata = 32'h8000_0000;
    @(posedge clk); #1;
    code_valid = 1'b0; en = 1'b0; we = 1'b0; wdata = '0;
    rd(1'b0, 32'h8008_0000, "ovf_set_wins");
    wr_status(32'h8000_0000);
    for (int i = 1; i <= 8; i++) rd(1'b1, 32'h8000_0000 | i, "drain");

    // Asynchronous reset mid-sequence
    send(8'h4D);
    send(8'hF0);
    #2 reset = 1'b0;
    #1;
    chk({31'b0, irq}, 32'd0, "async_rst_irq");
    en = 1'b1; addr = 32'd0; #1;
    chk(rdata, 32'h0000_0001, "async_rst_status");
    en = 1'b0; addr = '0;
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    send(8'h1C);
    rd(1'b1, 32'h8000_001C, "post_rst_make");
    rd(1'b0, 32'h0000_0001, "post_rst_empty");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
